// File: rtl/cgra_stream_packer.sv
// Packs valid CGRA lanes into dense AXI-Stream phits through an FWFT FIFO.
// Define CGRA_PACK_STATS_EN to add saturating stat_beats/stat_drops outputs.
module cgra_stream_packer #(
  parameter int PHIT_SIZE   = 512,
  parameter int SIMD_DEGREE = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len_lanes,
  input  logic [PHIT_SIZE-1:0]   stream_in,
  input  logic [SIMD_DEGREE-1:0] stream_in_valid,
  output logic [PHIT_SIZE-1:0]   m_axis_tdata,
  output logic [PHIT_SIZE/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef CGRA_PACK_STATS_EN
  ,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_drops
`endif
);
  localparam int LANE_W = PHIT_SIZE / SIMD_DEGREE;
  localparam int KB     = LANE_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(SIMD_DEGREE) + 1;
  localparam int EW     = PHIT_SIZE + SIMD_DEGREE + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_FLUSH, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [PHIT_SIZE-1:0]   stg_q, stg_d;
  logic [CW-1:0]          stg_cnt_q, stg_cnt_d;
  logic                   pv_q, pv_d;
  logic                   plast_q, plast_d;
  logic [PHIT_SIZE-1:0]   pdata_q, pdata_d;
  logic [SIMD_DEGREE-1:0] pkeep_q, pkeep_d;
  logic                   ovf_q, ovf_d;
  logic [AW:0]            wr_q, rd_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic                   empty, full;
  logic                   pop, push, drop;
  logic [2*PHIT_SIZE-1:0] cat;
  logic [CW-1:0]          idx, acc;
  logic [LEN_W-1:0]       rem_left;
  logic                   fill;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];
  assign pop   = m_axis_tvalid & m_axis_tready;
  // a same-cycle pop frees the slot, so a full FIFO only drops without one
  assign push  = pv_q & (~full | pop);
  assign drop  = pv_q & full & ~pop;

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = m_axis_tvalid ? head[PHIT_SIZE-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[EW-1];
  assign busy          = (state_q != S_IDLE);
  assign overflow      = ovf_q;

  always_comb begin
    m_axis_tkeep = '0;
    for (int k = 0; k < SIMD_DEGREE; k++) begin
      m_axis_tkeep[k*KB +: KB] =
        {KB{m_axis_tvalid & head[PHIT_SIZE+k]}};
    end
  end

  // append accepted lanes behind the staged ones, capped by remaining count
  always_comb begin
    cat = {{PHIT_SIZE{1'b0}}, stg_q};
    idx = stg_cnt_q;
    acc = '0;
    for (int k = 0; k < SIMD_DEGREE; k++) begin
      if (stream_in_valid[k] && (LEN_W'(acc) < rem_q)) begin
        cat[idx*LANE_W +: LANE_W] = stream_in[k*LANE_W +: LANE_W];
        idx = idx + CW'(1);
        acc = acc + CW'(1);
      end
    end
    rem_left = rem_q - LEN_W'(acc);
    fill     = (idx >= CW'(SIMD_DEGREE));
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stg_d     = stg_q;
    stg_cnt_d = stg_cnt_q;
    pv_d      = 1'b0;
    pdata_d   = pdata_q;
    pkeep_d   = pkeep_q;
    plast_d   = plast_q;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d     = len_lanes;
          stg_cnt_d = '0;
          state_d   = (len_lanes == '0) ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        rem_d = rem_left;
        if (fill) begin
          pv_d      = 1'b1;
          pdata_d   = cat[PHIT_SIZE-1:0];
          pkeep_d   = '1;
          plast_d   = (rem_left == '0) &&
                      (idx == CW'(SIMD_DEGREE));
          stg_d     = cat[2*PHIT_SIZE-1:PHIT_SIZE];
          stg_cnt_d = idx - CW'(SIMD_DEGREE);
        end else begin
          stg_d     = cat[PHIT_SIZE-1:0];
          stg_cnt_d = idx;
        end
        if (rem_left == '0) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (stg_cnt_q != '0) begin
          pv_d      = 1'b1;
          pdata_d   = stg_q;
          plast_d   = 1'b1;
          stg_cnt_d = '0;
          for (int k = 0; k < SIMD_DEGREE; k++) begin
            pkeep_d[k] = (CW'(k) < stg_cnt_q);
          end
        end
        // a dropped tlast beat can never handshake, so finish on the drop
        if ((pop && m_axis_tlast) || (drop && plast_q))
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | drop;
    if (state_q == S_IDLE && start) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      stg_cnt_q <= '0;
      pv_q      <= 1'b0;
      plast_q   <= 1'b0;
      pkeep_q   <= '0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      stg_cnt_q <= stg_cnt_d;
      pv_q      <= pv_d;
      plast_q   <= plast_d;
      pkeep_q   <= pkeep_d;
      ovf_q     <= ovf_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    stg_q   <= stg_d;
    pdata_q <= pdata_d;
    if (push) mem_q[wr_q[AW-1:0]] <= {plast_q, pkeep_q, pdata_q};
  end

`ifdef CGRA_PACK_STATS_EN
  logic [31:0] beats_q, drops_q;
  assign stat_beats = beats_q;
  assign stat_drops = drops_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q <= '0;
      drops_q <= '0;
    end else begin
      if (pop && beats_q != '1)  beats_q <= beats_q + 1'b1;
      if (drop && drops_q != '1) drops_q <= drops_q + 1'b1;
    end
  end
`endif
endmodule
